// File: rtl/dvp_pkg.sv
// Shared widths, FSM encoding and counter helper for the oversampling DVP receiver.
package dvp_pkg;

  localparam int unsigned DVP_DW = 8;
  localparam int unsigned PIX_DW = 16;
  localparam int unsigned CNT_W  = 11;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_VS,
    S_FRAME
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/dvp_sync_edge.sv
// Two-flop synchronizer for one asynchronous DVP pin, with rise/fall detect
// taken from the synchronized copy and one extra history flop.
module dvp_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sync = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/dvp_rx.sv
// Oversampling DVP receiver: pairs DVP bytes into RGB565 pixels, tags them with
// frame position and flags line/frame geometry errors.
module dvp_rx
  import dvp_pkg::*;
#(
  parameter int unsigned H_DISP    = 640,
  parameter int unsigned V_DISP    = 480,
  parameter bit          VSYNC_POL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              dvp_pclk,
  input  logic              dvp_vsync,
  input  logic              dvp_href,
  input  logic [DVP_DW-1:0] dvp_data,
  output logic              pix_valid,
  output logic [PIX_DW-1:0] pix_data,
  output logic [CNT_W-1:0]  pix_x,
  output logic [CNT_W-1:0]  pix_y,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              frame_done,
  output logic              line_err,
  output logic              frame_err,
  output logic [15:0]       frame_cnt
);

  localparam logic [CNT_W-1:0] H_LIM  = CNT_W'(H_DISP);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_DISP - 1);
  localparam logic [CNT_W-1:0] V_LIM  = CNT_W'(V_DISP);

  logic              pclk_s, pclk_rise, pclk_fall;
  logic              vsync_s, vsync_rise, vsync_fall;
  logic              href_s, href_rise, href_fall;
  logic [DVP_DW-1:0] data_s1, data_s2;

  dvp_sync_edge u_pclk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (dvp_pclk),
    .sync (pclk_s),
    .rise (pclk_rise),
    .fall (pclk_fall)
  );

  dvp_sync_edge u_vsync_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (dvp_vsync),
    .sync (vsync_s),
    .rise (vsync_rise),
    .fall (vsync_fall)
  );

  dvp_sync_edge u_href_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (dvp_href),
    .sync (href_s),
    .rise (href_rise),
    .fall (href_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      data_s1 <= '0;
      data_s2 <= '0;
    end else begin
      data_s1 <= dvp_data;
      data_s2 <= data_s1;
    end
  end

  logic unused_sync;
  assign unused_sync = &{1'b0, pclk_s, pclk_fall, vsync_s};

  state_t            state, state_nxt;
  logic              sample, vs_act, vs_inact;
  logic              in_frame, take, line_end, frame_end;
  logic              phase;
  logic [DVP_DW-1:0] hi_byte;
  logic [CNT_W-1:0]  col, row, row_after;

  assign sample   = pclk_rise;
  assign vs_act   = VSYNC_POL ? vsync_rise : vsync_fall;
  assign vs_inact = VSYNC_POL ? vsync_fall : vsync_rise;

  assign in_frame  = (state == S_FRAME);
  assign take      = in_frame && sample && href_s;
  // A line still open when vsync starts is closed here first, so the frame
  // check below sees the row count including it.
  assign line_end  = in_frame && (href_fall || (vs_act && href_s));
  assign frame_end = in_frame && vs_act;
  assign row_after = (line_end && (col != '0)) ? sat_inc(row) : row;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (enable && vs_act) state_nxt = S_VS;
      S_VS:    if (vs_inact) state_nxt = S_FRAME;
      S_FRAME: if (vs_act) state_nxt = enable ? S_VS : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase      <= 1'b0;
      hi_byte    <= '0;
      col        <= '0;
      row        <= '0;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_sof    <= 1'b0;
      pix_eol    <= 1'b0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      pix_valid  <= 1'b0;
      pix_sof    <= 1'b0;
      pix_eol    <= 1'b0;
      frame_done <= 1'b0;

      if (state == S_VS && vs_inact) row <= '0;

      if (href_rise) begin
        phase <= 1'b0;
        col   <= '0;
      end else if (take) begin
        if (!phase) begin
          hi_byte <= data_s2;
          phase   <= 1'b1;
        end else begin
          phase <= 1'b0;
          col   <= sat_inc(col);
          if (col < H_LIM && row < V_LIM) begin
            pix_valid <= 1'b1;
            pix_data  <= {hi_byte, data_s2};
            pix_x     <= col;
            pix_y     <= row;
            pix_sof   <= (col == '0) && (row == '0);
            pix_eol   <= (col == H_LAST);
          end
          if (col >= H_LIM) line_err <= 1'b1;
        end
      end

      if (line_end) begin
        if (phase || col != H_LIM) line_err <= 1'b1;
        row   <= row_after;
        phase <= 1'b0;
        col   <= '0;
      end

      if (frame_end) begin
        frame_done <= 1'b1;
        frame_cnt  <= frame_cnt + 16'd1;
        if (row_after != V_LIM) frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dvp_rx.sv
// Randomized bench for dvp_rx: a line/frame-level model predicts pixels, pulses
// and error flags from the bytes driven on the DVP pins.
module tb_dvp_rx;

  localparam int H = 4;
  localparam int V = 3;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [15:0] d;
    logic [10:0] x;
    logic [10:0] y;
    logic        sof;
    logic        eol;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst, enable, dvp_pclk, dvp_vsync, dvp_href;
  logic [7:0]  dvp_data;
  logic        pix_valid, pix_sof, pix_eol, frame_done, line_err, frame_err;
  logic [15:0] pix_data, frame_cnt;
  logic [10:0] pix_x, pix_y;

  dvp_rx #(.H_DISP(H), .V_DISP(V), .VSYNC_POL(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .dvp_pclk   (dvp_pclk),
    .dvp_vsync  (dvp_vsync),
    .dvp_href   (dvp_href),
    .dvp_data   (dvp_data),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_sof    (pix_sof),
    .pix_eol    (pix_eol),
    .frame_done (frame_done),
    .line_err   (line_err),
    .frame_err  (frame_err),
    .frame_cnt  (frame_cnt)
  );

  always #10 clk = ~clk;

  pix_t obs_q[$];
  pix_t exp_q[$];
  pix_t mon_p;
  int   obs_done = 0;
  int   stray    = 0;

  always @(negedge clk) begin
    if (pix_valid) begin
      mon_p.d   = pix_data;
      mon_p.x   = pix_x;
      mon_p.y   = pix_y;
      mon_p.sof = pix_sof;
      mon_p.eol = pix_eol;
      obs_q.push_back(mon_p);
    end
    if (frame_done) obs_done++;
    if (!pix_valid && (pix_sof || pix_eol)) stray++;
  end

  int          checks = 0;
  int          errors = 0;
  int          obs_base, done_base;
  bit          seq_mode;
  int          byte_ctr;
  bit          m_in_frame, m_line_err, m_frame_err;
  int          m_row, m_done;
  logic [15:0] m_frames;

  // Reference model: whole-line and whole-frame rules.
  function automatic void model_clear();
    m_in_frame = 0; m_row = 0; m_line_err = 0; m_frame_err = 0;
    m_frames = '0; m_done = 0; exp_q.delete();
    obs_base = obs_q.size(); done_base = obs_done; byte_ctr = 0;
  endfunction

  function automatic void model_line(input byte_q_t b);
    int   n;
    pix_t p;
    if (!m_in_frame) return;
    n = b.size() / 2;
    for (int x = 0; x < n; x++) begin
      if (x < H && m_row < V) begin
        p.d = {b[2*x], b[2*x+1]}; p.x = 11'(x); p.y = 11'(m_row);
        p.sof = (x == 0 && m_row == 0); p.eol = (x == H - 1);
        exp_q.push_back(p);
      end
    end
    if ((b.size() % 2) != 0 || n != H) m_line_err = 1;
    if (n > 0 && m_row < 2047) m_row++;
  endfunction

  function automatic void model_vsync();
    if (m_in_frame) begin
      m_done++; m_frames++;
      if (m_row != V) m_frame_err = 1;
    end
    m_in_frame = enable; m_row = 0;
  endfunction

  function automatic logic [7:0] gen_byte();
    logic [7:0] v;
    if (seq_mode) v = 8'((18 + 34 * byte_ctr) & 255);
    else          v = 8'($urandom_range(0, 255));
    byte_ctr++;
    return v;
  endfunction

  task automatic pclk_cyc(input logic h, input logic [7:0] d);
    dvp_href = h; dvp_data = d; dvp_pclk = 1'b0;
    repeat (2) @(negedge clk);
    dvp_pclk = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_line(input int nbytes);
    byte_q_t    b;
    logic [7:0] v;
    for (int i = 0; i < nbytes; i++) begin
      v = gen_byte(); b.push_back(v); pclk_cyc(1'b1, v);
    end
    repeat (2 + $urandom_range(0, 2)) pclk_cyc(1'b0, 8'h00);
    model_line(b);
  endtask

  task automatic vsync_pulse();
    model_vsync();
    dvp_vsync = 1'b1; repeat (2) pclk_cyc(1'b0, 8'h00);
    dvp_vsync = 1'b0; repeat (2) pclk_cyc(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    rst = 1'b1; dvp_pclk = 1'b0; dvp_href = 1'b0; dvp_vsync = 1'b0; dvp_data = '0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    enable = 1'b0;
    do_reset();
    checks++;
    if ({pix_valid, pix_sof, pix_eol, pix_data, pix_x, pix_y} !== '0) begin
      errors++; $display("FAIL reset_pix: got %0b/%h/%0d/%0d expected all 0", pix_valid, pix_data, pix_x, pix_y);
    end
    checks++;
    if ({frame_done, line_err, frame_err, frame_cnt} !== '0) begin
      errors++; $display("FAIL reset_status: got done=%0b le=%0b fe=%0b cnt=%0d expected 0", frame_done, line_err, frame_err, frame_cnt);
    end
  endtask

  task automatic test_nominal();
    int n;
    do_reset(); enable = 1'b1; seq_mode = 1;
    vsync_pulse();
    repeat (3) send_line(8);
    vsync_pulse();
    repeat (4) @(negedge clk);
    n = obs_q.size() - obs_base;
    checks++;
    if (n != 12 || exp_q.size() != 12) begin errors++; $display("FAIL nominal_count: got %0d model %0d expected 12", n, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      checks++;
      if (obs_q[obs_base+i] !== exp_q[i]) begin
        errors++; $display("FAIL nominal_pix%0d: got %h (%0d,%0d) expected %h (%0d,%0d)", i,
          obs_q[obs_base+i].d, obs_q[obs_base+i].x, obs_q[obs_base+i].y, exp_q[i].d, exp_q[i].x, exp_q[i].y);
      end
    end
    checks++;
    if (n == 0 || obs_q[obs_base].d !== 16'h1234 || obs_q[obs_base].sof !== 1'b1) begin
      errors++; $display("FAIL nominal_first: got n=%0d expected 1234 with sof", n);
    end
    checks++;
    if (obs_done - done_base != 1) begin errors++; $display("FAIL nominal_done: got %0d expected 1", obs_done - done_base); end
    checks++;
    if (frame_cnt !== 16'd1 || line_err !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL nominal_status: got cnt=%0d le=%0b fe=%0b expected 1/0/0", frame_cnt, line_err, frame_err);
    end
  endtask

  task automatic test_odd_bytes();
    int n;
    do_reset(); enable = 1'b1; seq_mode = 0;
    vsync_pulse();
    send_line(8); send_line(7); send_line(8);
    vsync_pulse();
    repeat (4) @(negedge clk);
    n = obs_q.size() - obs_base;
    checks++;
    if (n != 11 || exp_q.size() != 11) begin errors++; $display("FAIL odd_count: got %0d model %0d expected 11", n, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      checks++;
      if (obs_q[obs_base+i] !== exp_q[i]) begin
        errors++; $display("FAIL odd_pix%0d: got %h (%0d,%0d) expected %h (%0d,%0d)", i,
          obs_q[obs_base+i].d, obs_q[obs_base+i].x, obs_q[obs_base+i].y, exp_q[i].d, exp_q[i].x, exp_q[i].y);
      end
    end
    checks++;
    if (line_err !== 1'b1 || frame_err !== 1'b0 || obs_done - done_base != 1) begin
      errors++; $display("FAIL odd_status: got le=%0b fe=%0b done=%0d expected 1/0/1", line_err, frame_err, obs_done - done_base);
    end
  endtask

  task automatic test_long_line();
    int n;
    do_reset(); enable = 1'b1; seq_mode = 0;
    vsync_pulse();
    send_line(8); send_line(12); send_line(8);
    vsync_pulse();
    repeat (4) @(negedge clk);
    n = obs_q.size() - obs_base;
    checks++;
    if (n != 12 || exp_q.size() != 12) begin errors++; $display("FAIL long_count: got %0d model %0d expected 12", n, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      checks++;
      if (obs_q[obs_base+i] !== exp_q[i]) begin
        errors++; $display("FAIL long_pix%0d: got %h (%0d,%0d) expected %h (%0d,%0d)", i,
          obs_q[obs_base+i].d, obs_q[obs_base+i].x, obs_q[obs_base+i].y, exp_q[i].d, exp_q[i].x, exp_q[i].y);
      end
    end
    checks++;
    if (line_err !== 1'b1 || frame_err !== 1'b0 || frame_cnt !== 16'd1) begin
      errors++; $display("FAIL long_status: got le=%0b fe=%0b cnt=%0d expected 1/0/1", line_err, frame_err, frame_cnt);
    end
  endtask

  task automatic test_short_frame();
    do_reset(); enable = 1'b1; seq_mode = 0;
    vsync_pulse();
    repeat (2) send_line(8);
    vsync_pulse();
    repeat (4) @(negedge clk);
    checks++;
    if (obs_q.size() - obs_base != exp_q.size()) begin
      errors++; $display("FAIL short_count: got %0d expected %0d", obs_q.size() - obs_base, exp_q.size());
    end
    checks++;
    if (frame_err !== 1'b1 || line_err !== 1'b0 || frame_cnt !== 16'd1 || obs_done - done_base != 1) begin
      errors++; $display("FAIL short_status: got fe=%0b le=%0b cnt=%0d done=%0d expected 1/0/1/1",
        frame_err, line_err, frame_cnt, obs_done - done_base);
    end
  endtask

  task automatic test_enable_drop();
    int n;
    do_reset(); enable = 1'b1; seq_mode = 0;
    vsync_pulse();
    send_line(8);
    enable = 1'b0;
    repeat (2) send_line(8);
    vsync_pulse();
    repeat (3) send_line(8);
    vsync_pulse();
    repeat (4) @(negedge clk);
    n = obs_q.size() - obs_base;
    checks++;
    if (n != 12 || exp_q.size() != 12) begin errors++; $display("FAIL endrop_count: got %0d model %0d expected 12", n, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      checks++;
      if (obs_q[obs_base+i] !== exp_q[i]) begin
        errors++; $display("FAIL endrop_pix%0d: got %h expected %h", i, obs_q[obs_base+i].d, exp_q[i].d);
      end
    end
    checks++;
    if (frame_cnt !== 16'd1 || obs_done - done_base != 1) begin
      errors++; $display("FAIL endrop_frames: got cnt=%0d done=%0d expected 1/1", frame_cnt, obs_done - done_base);
    end
  endtask

  task automatic test_reset_midline();
    int n;
    do_reset(); enable = 1'b1; seq_mode = 0;
    vsync_pulse();
    send_line(10);
    for (int i = 0; i < 3; i++) pclk_cyc(1'b1, gen_byte());
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({pix_valid, pix_sof, pix_eol, pix_data, pix_x, pix_y, frame_done, line_err, frame_err, frame_cnt} !== '0) begin
      errors++; $display("FAIL midreset_zero: got x=%0d data=%h le=%0b expected all 0", pix_x, pix_data, line_err);
    end
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 3; i++) pclk_cyc(1'b1, gen_byte());
    repeat (3) pclk_cyc(1'b0, 8'h00);
    send_line(8);
    checks++;
    if (obs_q.size() - obs_base != 0) begin errors++; $display("FAIL midreset_quiet: got %0d pixels expected 0", obs_q.size() - obs_base); end
    vsync_pulse();
    repeat (3) send_line(8);
    vsync_pulse();
    repeat (4) @(negedge clk);
    n = obs_q.size() - obs_base;
    checks++;
    if (n != 12 || exp_q.size() != 12) begin errors++; $display("FAIL midreset_count: got %0d model %0d expected 12", n, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      checks++;
      if (obs_q[obs_base+i] !== exp_q[i]) begin
        errors++; $display("FAIL midreset_pix%0d: got %h expected %h", i, obs_q[obs_base+i].d, exp_q[i].d);
      end
    end
    checks++;
    if (frame_cnt !== 16'd1 || line_err !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL midreset_status: got cnt=%0d le=%0b fe=%0b expected 1/0/0", frame_cnt, line_err, frame_err);
    end
  endtask

  task automatic test_random();
    int n;
    int lens[7] = '{8, 8, 8, 7, 10, 6, 2};
    do_reset(); seq_mode = 0;
    for (int f = 0; f < 5; f++) begin
      enable = ($urandom_range(0, 3) != 0);
      vsync_pulse();
      for (int l = 0; l < int'($urandom_range(2, 4)); l++) send_line(lens[$urandom_range(0, 6)]);
    end
    vsync_pulse();
    repeat (4) @(negedge clk);
    n = obs_q.size() - obs_base;
    checks++;
    if (n != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", n, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      checks++;
      if (obs_q[obs_base+i] !== exp_q[i]) begin
        errors++; $display("FAIL rand_pix%0d: got %h (%0d,%0d) expected %h (%0d,%0d)", i,
          obs_q[obs_base+i].d, obs_q[obs_base+i].x, obs_q[obs_base+i].y, exp_q[i].d, exp_q[i].x, exp_q[i].y);
      end
    end
    checks++;
    if (frame_cnt !== m_frames || obs_done - done_base != m_done) begin
      errors++; $display("FAIL rand_frames: got cnt=%0d done=%0d expected %0d/%0d", frame_cnt, obs_done - done_base, m_frames, m_done);
    end
    checks++;
    if (line_err !== m_line_err || frame_err !== m_frame_err) begin
      errors++; $display("FAIL rand_errs: got le=%0b fe=%0b expected %0b/%0b", line_err, frame_err, m_line_err, m_frame_err);
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL stray_tags: got %0d sof/eol without valid expected 0", stray); end
  endtask

  task automatic test_wrap();
    do_reset(); enable = 1'b1; seq_mode = 0;
    vsync_pulse();
    force dut.frame_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.frame_cnt;
    m_frames = 16'hFFFE;
    for (int f = 0; f < 3; f++) begin
      send_line(2);
      vsync_pulse();
      repeat (2) @(negedge clk);
      checks++;
      if (frame_cnt !== m_frames) begin errors++; $display("FAIL wrap_cnt%0d: got %h expected %h", f, frame_cnt, m_frames); end
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; dvp_pclk = 1'b0; dvp_vsync = 1'b0; dvp_href = 1'b0; dvp_data = '0;
    test_reset();
    test_nominal();
    test_odd_bytes();
    test_long_line();
    test_short_frame();
    test_enable_drop();
    test_reset_midline();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dvp_rx.md
Name: dvp_rx

Overview:
- Oversampling DVP receiver: the receive end of the 8-bit DVP link driven by dvp_tx.
- Samples the DVP pins (pclk, vsync, href, data) asynchronously in the system clock domain and reassembles byte pairs into RGB565 pixels.
- Tags each pixel with frame and line position and checks frame geometry.
- Used for FPGA loopback self-test of the K230 video path and as the front end for a second camera channel.

Parameters:
- H_DISP, 640, expected pixels per line.
- V_DISP, 480, expected lines per frame.
- VSYNC_POL, 1, active level of dvp_vsync (1 = high during the blanking pulse).

Ports:
- clk  in  1  system sampling clock, 50 MHz; dvp_pclk must be ≤ clk/4.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  capture enable.
- dvp_pclk  in  1  DVP pixel clock, asynchronous.
- dvp_vsync  in  1  DVP frame sync, asynchronous.
- dvp_href  in  1  DVP line valid, asynchronous.
- dvp_data  in  8  DVP byte, asynchronous.
- pix_valid  out  1  one-cycle strobe, pixel word valid.
- pix_data  out  16  RGB565 pixel; first byte → [15:8].
- pix_x  out  11  pixel column, 0..H_DISP-1.
- pix_y  out  11  pixel row, 0..V_DISP-1.
- pix_sof  out  1  asserted with pix_valid for pixel (0,0).
- pix_eol  out  1  asserted with pix_valid for column H_DISP-1.
- frame_done  out  1  one-cycle pulse at end of frame.
- line_err  out  1  sticky: bad line length or odd byte count.
- frame_err  out  1  sticky: line count ≠ V_DISP.
- frame_cnt  out  16  completed-frame counter; wraps 0xFFFF→0.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state is updated on the rising edge of clk.
- Reset: all outputs 0, FSM → S_IDLE, byte phase cleared. Reset mid-frame discards partial data; the next capture starts only after a fresh vsync pulse.
- Input sync: pclk, vsync, href and data each pass through 2 flops, plus a third pclk flop for edge detect. sample = pclk_s2 & ~pclk_s3. vsync and href edges are detected the same way on synchronized copies. Data is taken from the synchronized copy at sample.
- Byte pairing on sample with href_s high:
  - phase 0: store byte → hi, phase←1.
  - phase 1: form {hi,byte}, phase←0.
  - Pixel emitted the cycle after the phase-1 sample (latency: 1 clk after sample; about 4 clk after the pin edge).
- Phase and column counters clear on the href rising edge.
- FSM:
  - S_IDLE: wait for enable=1 and vsync active edge → S_VS.
  - S_VS: wait for vsync inactive edge → S_FRAME; row←0.
  - S_FRAME: pixels are accepted.
    - href falling edge = end of line:
      - If phase=1 (odd byte count): drop the half pixel, set line_err.
      - If column count ≠ H_DISP: set line_err.
      - Row increments if ≥1 pixel was received.
    - vsync active edge = end of frame:
      - Pulse frame_done and increment frame_cnt.
      - If row ≠ V_DISP: set frame_err.
      - If enable=1 → S_VS, else → S_IDLE.
      - An unterminated href at this point is treated as an end of line first (same cycle ordering: line check, then frame check).
- Deasserting enable mid-frame does not truncate the frame; the frame completes, then the FSM idles.
- Overflow:
  - Pixels with column ≥ H_DISP: no pix_valid, counting continues, line_err set.
  - Rows ≥ V_DISP: pix_valid suppressed; counted.
  - Internal column and row counters saturate at 2047.
- Sticky errors clear only on rst.
- pix_sof and pix_eol are never asserted without pix_valid.

Decomposition:
- Package dvp_pkg: FSM state encoding (S_IDLE, S_VS, S_FRAME), DVP_DW=8, PIX_DW=16, CNT_W=11.
- Sub-module dvp_sync_edge: 2-flop synchronizer plus rise/fall detect. Instantiated for pclk, vsync and href; data uses plain 2-flop sync.

Test Plan:
- Nominal: pclk=clk/4, 4×3 frame with H_DISP=4, V_DISP=3, bytes 0x12,0x34,… → 12 pix_valid strobes.
  - First pix_data=0x1234 with pix_sof=1 at (0,0).
  - pix_eol at x=3.
  - frame_done once; frame_cnt=1; no errors.
- Odd bytes: one line with 7 bytes → 3 pixels output, line_err=1, frame continues, frame_done still pulses.
- Long line: 6 pixels with H_DISP=4 → pixels x=4,5 not emitted, line_err=1.
- Short frame: 2 lines with V_DISP=3 → frame_done pulses, frame_err=1, frame_cnt=1.
- Enable/reset:
  - enable dropped mid-frame → frame completes, then no pix_valid for the following frame.
  - rst asserted mid-line → all outputs 0 next cycle, no pixels until after the next full vsync pulse.
- Wrap: preload run of 65536 minimal frames (1×1) → frame_cnt returns to 0x0000.
